// File: rtl/usbls_pkg.sv
// Shared constants, state encoding and the reflected CRC16 byte step
// for the USB CRC16 streaming block.
package usbls_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // One byte, LSB first, right-shifting register.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  din
    );
        logic [15:0] c;
        c = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usbls_crc16_byte.sv
// Combinational single-byte CRC16 step; chained once per lane by the top.
module usbls_crc16_byte
    import usbls_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  din,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_byte(crc_in, din);

endmodule

// File: rtl/usbls_crc16_stream.sv
// Multi-lane USB CRC16 generator/checker with sop/eop framing and a
// one-deep result register on the output handshake.
module usbls_crc16_stream
    import usbls_pkg::*;
#(
    parameter int          LANES   = 8,
    parameter logic [15:0] INIT    = CRC16_INIT,
    parameter logic [15:0] RESIDUE = CRC16_RESIDUE,
    localparam int         BW      = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic [BW-1:0]        s_bytes,
    input  logic                 s_sop,
    input  logic                 s_eop,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [15:0]          m_crc,
    output logic                 m_crc_ok,
    output logic                 m_err
);

    state_t      state;
    logic [15:0] crc;
    logic        err;

    logic [15:0] taps [LANES+1];
    logic [15:0] next;
    logic [BW-1:0] sel;
    logic        over;
    logic        process;
    logic        pkt_err;
    logic        accept;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign taps[0] = s_sop ? INIT : crc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        usbls_crc16_byte u_byte (
            .crc_in  (taps[i]),
            .din     (s_data[8*i +: 8]),
            .crc_out (taps[i+1])
        );
    end

    always_comb begin
        over = s_bytes > BW'(LANES);
        sel  = over ? BW'(LANES) : s_bytes;
        next = taps[0];
        for (int i = 1; i <= LANES; i++) begin
            if (sel == BW'(i)) next = taps[i];
        end
        // A sop always restarts; outside a packet only sop beats count.
        process = s_sop || (state == ACTIVE);
        pkt_err = err || over
               || ((s_bytes == '0) && !s_eop)
               || (s_sop && (state == ACTIVE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            crc      <= INIT;
            err      <= 1'b0;
            m_valid  <= 1'b0;
            m_crc    <= 16'h0000;
            m_crc_ok <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            if (m_ready) m_valid <= 1'b0;
            if (accept) begin
                if (!process) begin
                    err <= 1'b1;
                end else if (s_eop) begin
                    m_valid  <= 1'b1;
                    m_crc    <= ~next;
                    m_crc_ok <= (next == RESIDUE);
                    m_err    <= pkt_err;
                    err      <= 1'b0;
                    crc      <= INIT;
                    state    <= IDLE;
                end else begin
                    crc   <= next;
                    err   <= pkt_err;
                    state <= ACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_usbls_crc16_stream.sv
// Scoreboard bench: three lane widths (8, 1, 3) driven with directed
// packets; a monitor per instance pops expected results as they appear.
module tb_usbls_crc16_stream;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [15:0] crc;
        logic        ok;
        logic        err;
        bit          chk_crc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sv[3], ss[3], se[3], mr[3];
    logic        sr[3], mv[3], mok[3], merr[3];
    logic [63:0] sd[3];
    logic [3:0]  sb[3];
    logic [15:0] mc[3];

    exp_t expq[3][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    usbls_crc16_stream #(.LANES(8)) u_l8 (
        .clk(clk), .rst(rst),
        .s_valid(sv[0]), .s_ready(sr[0]),
        .s_data(sd[0]), .s_bytes(sb[0]),
        .s_sop(ss[0]), .s_eop(se[0]),
        .m_valid(mv[0]), .m_ready(mr[0]),
        .m_crc(mc[0]), .m_crc_ok(mok[0]), .m_err(merr[0])
    );

    usbls_crc16_stream #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
        .s_valid(sv[1]), .s_ready(sr[1]),
        .s_data(sd[1][7:0]), .s_bytes(sb[1][0:0]),
        .s_sop(ss[1]), .s_eop(se[1]),
        .m_valid(mv[1]), .m_ready(mr[1]),
        .m_crc(mc[1]), .m_crc_ok(mok[1]), .m_err(merr[1])
    );

    usbls_crc16_stream #(.LANES(3)) u_l3 (
        .clk(clk), .rst(rst),
        .s_valid(sv[2]), .s_ready(sr[2]),
        .s_data(sd[2][23:0]), .s_bytes(sb[2][1:0]),
        .s_sop(ss[2]), .s_eop(se[2]),
        .m_valid(mv[2]), .m_ready(mr[2]),
        .m_crc(mc[2]), .m_crc_ok(mok[2]), .m_err(merr[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_mon
        always @(negedge clk) begin
            exp_t e;
            if (!rst && mv[k] && mr[k]) begin
                checks++;
                if (expq[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result cfg%0d: crc=%h ok=%b err=%b",
                             k, mc[k], mok[k], merr[k]);
                end else begin
                    e = expq[k].pop_front();
                    if ((e.chk_crc && mc[k] !== e.crc) ||
                        mok[k] !== e.ok || merr[k] !== e.err) begin
                        errors++;
                        $display("FAIL result cfg%0d: got crc=%h ok=%b err=%b, expected crc=%h ok=%b err=%b (crc checked=%0d)",
                                 k, mc[k], mok[k], merr[k],
                                 e.crc, e.ok, e.err, e.chk_crc);
                    end
                end
            end
        end
    end

    function automatic int lanes(int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic bq_t str9();
        bq_t q;
        for (int i = 1; i <= 9; i++) q.push_back(8'(8'h30 + i));
        return q;
    endfunction

    function automatic logic [63:0] pack(bq_t q, int from, int n);
        logic [63:0] d = '0;
        for (int j = 0; j < n; j++) d[8*j +: 8] = q[from+j];
        return d;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push(int k, logic [15:0] crc, logic ok, logic err, bit cc);
        exp_t e;
        e.crc = crc; e.ok = ok; e.err = err; e.chk_crc = cc;
        expq[k].push_back(e);
    endtask

    task automatic beat(int k, logic [63:0] d, int nb, bit sop, bit eop);
        bit rdy;
        int n = 0;
        sv[k] = 1'b1; sd[k] = d; sb[k] = 4'(nb);
        ss[k] = sop;  se[k] = eop;
        do begin
            @(negedge clk);
            rdy = sr[k];
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cfg%0d: s_ready stuck at %b, expected 1", k, sr[k]);
        end
        sv[k] = 1'b0; ss[k] = 1'b0; se[k] = 1'b0;
    endtask

    task automatic pkt(int k, bq_t q, logic [15:0] crc, logic ok, logic err, bit cc);
        int i = 0;
        int n;
        push(k, crc, ok, err, cc);
        if (q.size() == 0) beat(k, '0, 0, 1'b1, 1'b1);
        while (i < q.size()) begin
            n = (q.size() - i < lanes(k)) ? q.size() - i : lanes(k);
            beat(k, pack(q, i, n), n, i == 0, i + n == q.size());
            i += n;
        end
    endtask

    task automatic drain(int k);
        int n = 0;
        while (expq[k].size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expq[k].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain cfg%0d: %0d results missing, expected 0", k, expq[k].size());
        end
    endtask

    initial begin
        bq_t q9, q11, qf, qe;
        q9  = str9();
        q11 = str9();
        q11.push_back(8'hC8);
        q11.push_back(8'hB4);
        qf = q11;
        qf[3] = qf[3] ^ 8'h01;

        for (int k = 0; k < 3; k++) begin
            sv[k] = 0; ss[k] = 0; se[k] = 0;
            sd[k] = '0; sb[k] = '0; mr[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", 32'(mv[0]), 0);
        chk("reset_m_crc", 32'(mc[0]), 0);
        chk("reset_m_crc_ok", 32'(mok[0]), 0);
        chk("reset_m_err", 32'(merr[0]), 0);
        chk("reset_s_ready", 32'(sr[0]), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8+1 byte packet, result one cycle after eop
        push(0, 16'hB4C8, 1'b0, 1'b0, 1'b1);
        beat(0, pack(q9, 0, 8), 8, 1'b1, 1'b0);
        beat(0, pack(q9, 8, 1), 1, 1'b0, 1'b1);
        chk("latency_m_valid", 32'(mv[0]), 1);

        pkt(0, q11, 16'h4FFE, 1'b1, 1'b0, 1'b1);
        pkt(0, qf, 16'h0000, 1'b0, 1'b0, 1'b0);
        pkt(0, qe, 16'h0000, 1'b0, 1'b0, 1'b1);
        drain(0);

        // held result, then back-to-back release
        mr[0] = 1'b0;
        fork
            begin
                pkt(0, q9, 16'hB4C8, 1'b0, 1'b0, 1'b1);
                pkt(0, q11, 16'h4FFE, 1'b1, 1'b0, 1'b1);
                pkt(0, q9, 16'hB4C8, 1'b0, 1'b0, 1'b1);
            end
            begin
                int n = 0;
                while (!mv[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("hold_m_valid", 32'(mv[0]), 1);
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_s_ready", 32'(sr[0]), 0);
                    chk("hold_m_crc", 32'(mc[0]), 32'hB4C8);
                end
                @(posedge clk);
                #1;
                mr[0] = 1'b1;
            end
        join
        drain(0);

        // restart mid-packet, discarded beat, clamp, zero-byte middle beat
        beat(0, pack(q9, 0, 4), 4, 1'b1, 1'b0);
        pkt(0, q9, 16'hB4C8, 1'b0, 1'b1, 1'b1);
        beat(0, pack(q9, 0, 2), 2, 1'b0, 1'b0);
        pkt(0, q9, 16'hB4C8, 1'b0, 1'b1, 1'b1);
        pkt(0, q9, 16'hB4C8, 1'b0, 1'b0, 1'b1);
        push(0, 16'hB4C8, 1'b0, 1'b1, 1'b1);
        beat(0, pack(q9, 0, 8), 9, 1'b1, 1'b0);
        beat(0, pack(q9, 8, 1), 1, 1'b0, 1'b1);
        push(0, 16'hB4C8, 1'b0, 1'b1, 1'b1);
        beat(0, pack(q9, 0, 8), 8, 1'b1, 1'b0);
        beat(0, '0, 0, 1'b0, 1'b0);
        beat(0, pack(q9, 8, 1), 1, 1'b0, 1'b1);
        drain(0);

        // reset drops a held result and a partial packet
        mr[0] = 1'b0;
        beat(0, pack(q9, 0, 8), 8, 1'b1, 1'b0);
        beat(0, pack(q9, 8, 1), 1, 1'b0, 1'b1);
        chk("pre_reset_m_valid", 32'(mv[0]), 1);
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(mv[0]), 0);
        chk("rst_s_ready", 32'(sr[0]), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mr[0] = 1'b1;
        beat(0, pack(q9, 0, 8), 8, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pkt(0, q9, 16'hB4C8, 1'b0, 1'b0, 1'b1);
        drain(0);

        for (int k = 1; k < 3; k++) begin
            pkt(k, q9, 16'hB4C8, 1'b0, 1'b0, 1'b1);
            pkt(k, q11, 16'h4FFE, 1'b1, 1'b0, 1'b1);
            pkt(k, qf, 16'h0000, 1'b0, 1'b0, 1'b0);
            drain(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
